// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder cell.
// The saturating increment works on 32-bit values, so counters up to 32 bits wide are supported.
package half_adder_pkg;

    localparam int CNT_W_DEFAULT = 16;

    function automatic logic [31:0] satInc(input logic [31:0] value, input logic [31:0] maxVal);
        return (value >= maxVal) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/half_adder_ha_bit.sv
// One-lane combinational half adder.
module ha_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder with zero-latency outputs, a registered copy and a saturating carry-event counter.
// Lanes are independent, so no carry ever travels between neighbouring lanes.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : gLane
        ha_bit uBit (
            .a    (a[i]),
            .b    (b[i]),
            .sum  (sum[i]),
            .carry(carry[i])
        );
    end

    // Registered copy holds on idle cycles; a clear beats a same-cycle increment.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        cnt_d   = cnt_q;
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && (|carry)) begin
            cnt_d = CNT_W'(satInc(32'(cnt_q), 32'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a 1-lane, a 4-lane and a 2-bit-counter instance share clock and reset.
module tb_half_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        a1 = 1'b0, b1 = 1'b0, inValid1 = 1'b0, cntClr1 = 1'b0;
    logic        sum1, carry1, sumQ1, carryQ1, outValid1;
    logic [15:0] cnt1;

    logic [3:0]  a4 = 4'd0, b4 = 4'd0;
    logic        inValid4 = 1'b0, cntClr4 = 1'b0;
    logic [3:0]  sum4, carry4, sumQ4, carryQ4;
    logic        outValid4;
    logic [15:0] cnt4;

    logic        aS = 1'b0, bS = 1'b0, inValidS = 1'b0, cntClrS = 1'b0;
    logic        sumS, carryS, sumQS, carryQS, outValidS;
    logic [1:0]  cntS;

    int checkCount = 0;
    int errorCount = 0;

    logic [1:0] combAB    [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic       combSum   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       combCarry [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] satExp    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sum(sum1), .carry(carry1),
        .in_valid(inValid1), .cnt_clr(cntClr1), .sum_q(sumQ1), .carry_q(carryQ1),
        .out_valid(outValid1), .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .sum(sum4), .carry(carry4),
        .in_valid(inValid4), .cnt_clr(cntClr4), .sum_q(sumQ4), .carry_q(carryQ4),
        .out_valid(outValid4), .carry_cnt(cnt4)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .a(aS), .b(bS), .sum(sumS), .carry(carryS),
        .in_valid(inValidS), .cnt_clr(cntClrS), .sum_q(sumQS), .carry_q(carryQS),
        .out_valid(outValidS), .carry_cnt(cntS)
    );

    task automatic test_reset();
        #2;
        checkCount++;
        if (sumQ1 !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_sum_q got %0h expected 0", sumQ1); end
        checkCount++;
        if (carryQ1 !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_carry_q got %0h expected 0", carryQ1); end
        checkCount++;
        if (outValid1 !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_out_valid got %0h expected 0", outValid1); end
        checkCount++;
        if (cnt1 !== 16'd0) begin errorCount++; $display("[TB] FAIL reset_cnt got %0d expected 0", cnt1); end
        checkCount++;
        if (cntS !== 2'd0) begin errorCount++; $display("[TB] FAIL reset_cnt_sat got %0d expected 0", cntS); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb();
        for (int i = 0; i < 5; i++) begin
            a1 = combAB[i][1];
            b1 = combAB[i][0];
            #20;
            checkCount++;
            if (sum1 !== combSum[i]) begin
                errorCount++;
                $display("[TB] FAIL comb_sum[%0d] ab=%b got %b expected %b", i, combAB[i], sum1, combSum[i]);
            end
            checkCount++;
            if (carry1 !== combCarry[i]) begin
                errorCount++;
                $display("[TB] FAIL comb_carry[%0d] ab=%b got %b expected %b", i, combAB[i], carry1, combCarry[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        inValid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (sumQ1 !== 1'b0) begin errorCount++; $display("[TB] FAIL reg_sum_q got %b expected 0", sumQ1); end
        checkCount++;
        if (carryQ1 !== 1'b1) begin errorCount++; $display("[TB] FAIL reg_carry_q got %b expected 1", carryQ1); end
        checkCount++;
        if (outValid1 !== 1'b1) begin errorCount++; $display("[TB] FAIL reg_out_valid got %b expected 1", outValid1); end
        @(negedge clk);
        inValid1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (sumQ1 !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_sum_q got %b expected 0", sumQ1); end
        checkCount++;
        if (carryQ1 !== 1'b1) begin errorCount++; $display("[TB] FAIL hold_carry_q got %b expected 1", carryQ1); end
        checkCount++;
        if (outValid1 !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_out_valid got %b expected 0", outValid1); end
        checkCount++;
        if (cnt1 !== 16'd1) begin errorCount++; $display("[TB] FAIL reg_cnt got %0d expected 1", cnt1); end
    endtask

    task automatic test_counter();
        @(negedge clk);
        cntClr1 = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (cnt1 !== 16'd0) begin errorCount++; $display("[TB] FAIL cnt_clear got %0d expected 0", cnt1); end
        @(negedge clk);
        cntClr1 = 1'b0; inValid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (cnt1 !== 16'(i)) begin errorCount++; $display("[TB] FAIL cnt_inc[%0d] got %0d expected %0d", i, cnt1, i); end
        end
        @(negedge clk);
        b1 = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (cnt1 !== 16'd3) begin errorCount++; $display("[TB] FAIL cnt_no_carry got %0d expected 3", cnt1); end
        @(negedge clk);
        b1 = 1'b1; cntClr1 = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (cnt1 !== 16'd0) begin errorCount++; $display("[TB] FAIL cnt_clear_wins got %0d expected 0", cnt1); end
        @(negedge clk);
        cntClr1 = 1'b0; inValid1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inValid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkCount++;
        if (cnt1 !== 16'd5 || carryQ1 !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL premid_state cnt=%0d carry_q=%b expected 5 and 1", cnt1, carryQ1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (carryQ1 !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_carry_q got %b expected 0", carryQ1); end
        checkCount++;
        if (cnt1 !== 16'd0) begin errorCount++; $display("[TB] FAIL mid_cnt got %0d expected 0", cnt1); end
        checkCount++;
        if (outValid1 !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_out_valid got %b expected 0", outValid1); end
        checkCount++;
        if (sum1 !== 1'b0 || carry1 !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL mid_comb sum=%b carry=%b expected 0 and 1", sum1, carry1);
        end
        @(negedge clk);
        rst_n = 1'b1; inValid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (carryQ1 !== 1'b0 || cnt1 !== 16'd0) begin
            errorCount++;
            $display("[TB] FAIL mid_discard carry_q=%b cnt=%0d expected 0 and 0", carryQ1, cnt1);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        inValidS = 1'b1; aS = 1'b1; bS = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (cntS !== satExp[i]) begin
                errorCount++;
                $display("[TB] FAIL sat_cnt[%0d] got %0d expected %0d", i, cntS, satExp[i]);
            end
        end
        @(negedge clk);
        inValidS = 1'b0;
    endtask

    task automatic test_wide();
        @(negedge clk);
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        checkCount++;
        if (sum4 !== 4'b0110) begin errorCount++; $display("[TB] FAIL wide_sum got %b expected 0110", sum4); end
        checkCount++;
        if (carry4 !== 4'b1000) begin errorCount++; $display("[TB] FAIL wide_carry got %b expected 1000", carry4); end
        inValid4 = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (sumQ4 !== 4'b0110 || carryQ4 !== 4'b1000 || outValid4 !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL wide_reg sum_q=%b carry_q=%b valid=%b expected 0110 1000 1", sumQ4, carryQ4, outValid4);
        end
        checkCount++;
        if (cnt4 !== 16'd1) begin errorCount++; $display("[TB] FAIL wide_cnt got %0d expected 1", cnt4); end
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b1010;
        #1;
        checkCount++;
        if (sum4 !== 4'b1111 || carry4 !== 4'b0000) begin
            errorCount++;
            $display("[TB] FAIL wide_comb2 sum=%b carry=%b expected 1111 0000", sum4, carry4);
        end
        @(posedge clk); #1;
        checkCount++;
        if (cnt4 !== 16'd1 || sumQ4 !== 4'b1111) begin
            errorCount++;
            $display("[TB] FAIL wide_no_carry cnt=%0d sum_q=%b expected 1 1111", cnt4, sumQ4);
        end
        @(negedge clk);
        inValid4 = 1'b0;
    endtask

    initial begin
        $display("[TB] starting half_adder bench");
        test_reset();
        test_comb();
        test_registered();
        test_counter();
        test_reset_mid();
        test_saturation();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
